// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle for the N-to-1 round-robin/fixed-select multiplexer.
// slave = the mux itself, master = the side driving channels and draining the output.
interface mux_nto1_rr_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_chan;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/mux_nto1_rr.sv
// N-to-1 multiplexer with fixed-select or round-robin arbitration and a single
// registered output stage that can drain and reload in the same cycle.
module mux_nto1_rr_lane #(
  parameter int WIDTH = 8,
  parameter int SELW  = 2,
  parameter int IDX   = 0
) (
  input  logic             grant_vld,
  input  logic [SELW-1:0]  grant,
  input  logic [WIDTH-1:0] data,
  output logic             hit,
  output logic [WIDTH-1:0] data_m
);
  assign hit    = grant_vld && (grant == SELW'(IDX));
  assign data_m = hit ? data : '0;
endmodule

module mux_nto1_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input logic          clk,
  input logic          rst_n,
  mux_nto1_rr_if.slave bus
);
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             load_en;
  logic             xfer;
  logic [N-1:0]     hit;
  logic [WIDTH-1:0] data_m [N];
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_chan_q;
  logic             out_valid_q;

  assign load_en = !out_valid_q || bus.out_ready;

  // Fixed mode matches sel against each lane index, so an out-of-range sel
  // (possible when N is not a power of two) simply yields no grant.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    if (!bus.mode) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(bus.sel) == i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SELW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!grant_vld && bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant     = SELW'(idx);
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_nto1_rr_lane #(.WIDTH(WIDTH), .SELW(SELW), .IDX(i)) u_lane (
      .grant_vld (grant_vld),
      .grant     (grant),
      .data      (bus.in_data[i*WIDTH +: WIDTH]),
      .hit       (hit[i]),
      .data_m    (data_m[i])
    );
  end

  // Lanes zero their data unless granted, so an OR tree is the selector.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) sel_data = sel_data | data_m[i];
  end

  assign bus.in_ready = hit & {N{load_en && rst_n}};
  assign xfer         = |bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr      <= '0;
    end else begin
      if (load_en) begin
        out_valid_q <= grant_vld;
        if (grant_vld) begin
          out_data_q <= sel_data;
          out_chan_q <= grant;
        end
      end
      if (bus.mode && xfer)
        rr_ptr <= (grant == SELW'(N-1)) ? '0 : grant + 1'b1;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: stimulus pushes expected {chan,data} words,
// an independent monitor pops them on every output transfer.
module tb_mux_nto1_rr;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [9:0] sb [$];

  always #5 clk = ~clk;

  mux_nto1_rr_if #(.WIDTH(8), .N(4)) bus ();
  mux_nto1_rr_if #(.WIDTH(8), .N(3)) bus3 ();

  mux_nto1_rr #(.WIDTH(8), .N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mux_nto1_rr #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input int k);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(k*16 + i);
    return d;
  endfunction

  // One cycle of stimulus; checks in_ready and queues the word it should load.
  task automatic step(input logic [3:0] v, input logic m, input logic [1:0] s,
                      input logic ordy, input logic [31:0] d, input logic [3:0] exp_rdy,
                      input logic push, input logic [1:0] ch, input string nm);
    @(posedge clk); #1;
    bus.in_valid  = v;
    bus.mode      = m;
    bus.sel       = s;
    bus.out_ready = ordy;
    bus.in_data   = d;
    #1;
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    if (push) sb.push_back({ch, d[ch*8 +: 8]});
  endtask

  // Monitor: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h required=none", {bus.out_chan, bus.out_data});
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("out_word", 32'({bus.out_chan, bus.out_data}), 32'(e));
      end
    end
  end

  // N=3 build with sel=3 must never grant.
  initial begin
    bus3.in_data   = 24'hCCBBAA;
    bus3.in_valid  = 3'b111;
    bus3.mode      = 1'b0;
    bus3.sel       = 2'd3;
    bus3.out_ready = 1'b1;
    repeat (25) begin
      @(negedge clk);
      chk("n3_in_ready", 32'(bus3.in_ready), 32'd0);
      chk("n3_out_valid", 32'(bus3.out_valid), 32'd0);
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.mode      = 1'b1;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;
    bus.in_data   = mkdata(1);
    repeat (2) @(posedge clk);
    #2;
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", 32'(bus.out_data), 32'd0);
    chk("rst out_chan", 32'(bus.out_chan), 32'd0);
    bus.in_valid = 4'b0000;
    rst_n        = 1'b1;

    // Fixed select of channel 2.
    step(4'b1111, 1'b0, 2'd2, 1'b1, 32'h00A5_0000, 4'b0100, 1'b1, 2'd2, "fixed_sel2");

    // Round-robin over all four channels, two full laps.
    for (int k = 0; k < 8; k++)
      step(4'b1111, 1'b1, 2'd0, 1'b1, mkdata(k), 4'(1 << (k % 4)), 1'b1, 2'(k % 4), "rr_all");

    // Sparse requesters: 1,3,1,3.
    for (int k = 0; k < 4; k++)
      step(4'b1010, 1'b1, 2'd0, 1'b1, mkdata(k + 2),
           (k % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1, (k % 2 == 0) ? 2'd1 : 2'd3, "rr_sparse");

    // Load 0x3C from channel 1, then stall three cycles.
    step(4'b0010, 1'b1, 2'd0, 1'b1, 32'h0000_3C00, 4'b0010, 1'b1, 2'd1, "stall_load");
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 1'b1, 2'd0, 1'b0, mkdata(9), 4'b0000, 1'b0, 2'd0, "stall");
      chk("stall out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall out_data", 32'(bus.out_data), 32'h3C);
      chk("stall out_chan", 32'(bus.out_chan), 32'd1);
    end
    // Release: drain 0x3C and load channel 2 in the same cycle.
    step(4'b1111, 1'b1, 2'd0, 1'b1, mkdata(9), 4'b0100, 1'b1, 2'd2, "release");

    // Fixed select of an idle channel: no grant, output empties.
    step(4'b0111, 1'b0, 2'd3, 1'b1, mkdata(10), 4'b0000, 1'b0, 2'd0, "idle_sel3");
    step(4'b0111, 1'b0, 2'd3, 1'b1, mkdata(10), 4'b0000, 1'b0, 2'd0, "idle_sel3b");
    chk("idle out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle out_chan", 32'(bus.out_chan), 32'd2);

    // Reset in the middle of a stall discards the held word.
    step(4'b0001, 1'b0, 2'd0, 1'b1, mkdata(5), 4'b0001, 1'b1, 2'd0, "pre_stall");
    step(4'b1111, 1'b1, 2'd0, 1'b0, mkdata(6), 4'b0000, 1'b0, 2'd0, "rst_stall");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    sb.delete();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = mkdata(7);
    #1;
    chk("post_rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst in_ready", 32'(bus.in_ready), 32'b0001);
    sb.push_back({2'd0, 8'h70});
    step(4'b1111, 1'b1, 2'd0, 1'b1, mkdata(8), 4'b0010, 1'b1, 2'd1, "post_rst2");
    step(4'b0000, 1'b1, 2'd0, 1'b1, mkdata(8), 4'b0000, 1'b0, 2'd0, "drain");
    step(4'b0000, 1'b1, 2'd0, 1'b1, mkdata(8), 4'b0000, 1'b0, 2'd0, "drain2");
    @(negedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
